// File: rtl/quad_mux_arbiter.sv
// quad_mux_arbiter
//   Round-robin arbiter and sequencer for a shared quad 2-to-1 multiplexer.
//   Two 4-bit sources (A, B) compete for the bus. The block drives the mux
//   select S and disable E, issues grants, and registers the transferred
//   nibble onto Y with a one-cycle Y_VALID strobe. A per-grant beat limit
//   (MAX_HOLD) forces a hand-over when the other side is waiting.
//
// Handshake: a beat happens in any cycle where GNT_x=1 and REQ_x=1; the data
//   on that side is sampled at the following rising edge and appears on Y
//   with Y_VALID=1. Data must stay stable while REQ_x is high.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   REQ_A, A        source A request and data
//   REQ_B, B        source B request and data
//   GNT_A, GNT_B    grant (from registered state only)
//   S               mux select (0 = A, 1 = B); holds last grant in IDLE
//   E               mux disable (1 = Y of the mux forced to 0)
//   Y, Y_VALID      registered transferred nibble and its strobe
//   dbg_state       current FSM state (0 IDLE, 1 GRANT_A, 2 GRANT_B)
module quad_mux_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_A,
  input  logic [3:0] A,
  input  logic       REQ_B,
  input  logic [3:0] B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       S,
  output logic       E,
  output logic [3:0] Y,
  output logic       Y_VALID,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  // last side encoding: 0 = A, 1 = B
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             s_q, s_d;
  logic [3:0]       y_q, y_d;
  logic             y_valid_q, y_valid_d;

  logic at_limit;
  logic enter_a;
  logic enter_b;

  assign at_limit = (cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    s_d       = s_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    enter_a   = 1'b0;
    enter_b   = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ_A && REQ_B) begin
          // tie goes to the side that was not granted last
          if (last_q) enter_a = 1'b1;
          else        enter_b = 1'b1;
        end else if (REQ_A) begin
          enter_a = 1'b1;
        end else if (REQ_B) begin
          enter_b = 1'b1;
        end
      end

      GRANT_A: begin
        if (!REQ_A) begin
          if (REQ_B) enter_b = 1'b1;
          else       state_d = IDLE;
        end else begin
          y_d       = A;
          y_valid_d = 1'b1;
          if (at_limit) begin
            // limit reached: hand over if B waits, otherwise wrap and keep A
            if (REQ_B) enter_b = 1'b1;
            else       cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      GRANT_B: begin
        if (!REQ_B) begin
          if (REQ_A) enter_a = 1'b1;
          else       state_d = IDLE;
        end else begin
          y_d       = B;
          y_valid_d = 1'b1;
          if (at_limit) begin
            if (REQ_A) enter_a = 1'b1;
            else       cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // entering a grant restarts the beat count and records the owner
    if (enter_a) begin
      state_d = GRANT_A;
      cnt_d   = '0;
      last_d  = 1'b0;
      s_d     = 1'b0;
    end else if (enter_b) begin
      state_d = GRANT_B;
      cnt_d   = '0;
      last_d  = 1'b1;
      s_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      s_q       <= 1'b0;
      y_q       <= 4'h0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      s_q       <= s_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign GNT_A     = (state_q == GRANT_A);
  assign GNT_B     = (state_q == GRANT_B);
  assign S         = s_q;
  assign E         = !(GNT_A || GNT_B);
  assign Y         = y_q;
  assign Y_VALID   = y_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_quad_mux_arbiter.sv
// Testbench for quad_mux_arbiter: table of directed vectors against a
// MAX_HOLD=4 instance, plus a hand-written alternation sequence against a
// MAX_HOLD=1 instance.
module tb_quad_mux_arbiter;

  logic       clk;
  logic       rst, req_a, req_b;
  logic [3:0] a, b;
  logic       gnt_a, gnt_b, s, e, y_valid;
  logic [3:0] y;
  logic [1:0] dbg_state;

  logic       rst1, req_a1, req_b1;
  logic [3:0] a1, b1;
  logic       gnt_a1, gnt_b1, s1, e1, y_valid1;
  logic [3:0] y1;
  logic [1:0] dbg_state1;

  int checks = 0;
  int errors = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  quad_mux_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst), .REQ_A(req_a), .A(a), .REQ_B(req_b), .B(b),
    .GNT_A(gnt_a), .GNT_B(gnt_b), .S(s), .E(e), .Y(y), .Y_VALID(y_valid),
    .dbg_state(dbg_state)
  );

  quad_mux_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
    .CLK(clk), .RST(rst1), .REQ_A(req_a1), .A(a1), .REQ_B(req_b1), .B(b1),
    .GNT_A(gnt_a1), .GNT_B(gnt_b1), .S(s1), .E(e1), .Y(y1), .Y_VALID(y_valid1),
    .dbg_state(dbg_state1)
  );

  typedef struct {
    logic       rst;
    logic       req_a;
    logic [3:0] a;
    logic       req_b;
    logic [3:0] b;
    logic       gnt_a;
    logic       gnt_b;
    logic       s;
    logic       e;
    logic [3:0] y;
    logic       y_valid;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs[NV];

  // scoreboard expected queue for the MAX_HOLD=1 Y sequence
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic r, logic ra, logic [3:0] av, logic rb, logic [3:0] bv,
                              logic ga, logic gb, logic sv, logic ev, logic [3:0] yv, logic vv);
    vec_t v;
    v.rst = r; v.req_a = ra; v.a = av; v.req_b = rb; v.b = bv;
    v.gnt_a = ga; v.gnt_b = gb; v.s = sv; v.e = ev; v.y = yv; v.y_valid = vv;
    return v;
  endfunction

  initial begin
    // reset with both requesting
    vecs[0]  = mk(1, 1, 4'h0, 1, 4'h0,  0, 0, 0, 1, 4'h0, 0);
    vecs[1]  = mk(1, 1, 4'h0, 1, 4'h0,  0, 0, 0, 1, 4'h0, 0);
    vecs[2]  = mk(0, 1, 4'h1, 1, 4'h0,  1, 0, 0, 0, 4'h0, 0); // first tie -> A
    // single source, A stepping 1,2,3
    vecs[3]  = mk(0, 1, 4'h1, 0, 4'h0,  1, 0, 0, 0, 4'h1, 1);
    vecs[4]  = mk(0, 1, 4'h2, 0, 4'h0,  1, 0, 0, 0, 4'h2, 1);
    vecs[5]  = mk(0, 1, 4'h3, 0, 4'h0,  1, 0, 0, 0, 4'h3, 1);
    vecs[6]  = mk(0, 0, 4'h0, 0, 4'h0,  0, 0, 0, 1, 4'h3, 0);
    vecs[7]  = mk(0, 0, 4'h0, 0, 4'h0,  0, 0, 0, 1, 4'h3, 0);
    // contention; LAST=A so the tie goes to B first
    vecs[8]  = mk(0, 1, 4'hA, 1, 4'h5,  0, 1, 1, 0, 4'h3, 0);
    vecs[9]  = mk(0, 1, 4'hA, 1, 4'h5,  0, 1, 1, 0, 4'h5, 1);
    vecs[10] = mk(0, 1, 4'hA, 1, 4'h5,  0, 1, 1, 0, 4'h5, 1);
    vecs[11] = mk(0, 1, 4'hA, 1, 4'h5,  0, 1, 1, 0, 4'h5, 1);
    vecs[12] = mk(0, 1, 4'hA, 1, 4'h5,  1, 0, 0, 0, 4'h5, 1); // 4th B beat, hand-over
    vecs[13] = mk(0, 1, 4'hA, 1, 4'h5,  1, 0, 0, 0, 4'hA, 1);
    vecs[14] = mk(0, 1, 4'hA, 1, 4'h5,  1, 0, 0, 0, 4'hA, 1);
    vecs[15] = mk(0, 1, 4'hA, 1, 4'h5,  1, 0, 0, 0, 4'hA, 1);
    vecs[16] = mk(0, 1, 4'hA, 1, 4'h5,  0, 1, 1, 0, 4'hA, 1); // 4th A beat, hand-over
    vecs[17] = mk(0, 0, 4'h0, 0, 4'h0,  0, 0, 1, 1, 4'hA, 0); // IDLE keeps S=1
    // hold wrap: A alone for 10 beats
    vecs[18] = mk(0, 1, 4'h6, 0, 4'h0,  1, 0, 0, 0, 4'hA, 0);
    for (int i = 19; i <= 28; i++)
      vecs[i] = mk(0, 1, 4'h6, 0, 4'h0, 1, 0, 0, 0, 4'h6, 1);
    // A releases with B requesting -> direct hand-over, no beat
    vecs[29] = mk(0, 0, 4'h0, 1, 4'h9,  0, 1, 1, 0, 4'h6, 0);
    vecs[30] = mk(0, 0, 4'h0, 1, 4'h9,  0, 1, 1, 0, 4'h9, 1);
    vecs[31] = mk(0, 1, 4'h7, 1, 4'h9,  0, 1, 1, 0, 4'h9, 1);
    vecs[32] = mk(0, 1, 4'h7, 0, 4'h0,  1, 0, 0, 0, 4'h9, 0); // early release after 2 B beats
    // reset on the 3rd A beat
    vecs[33] = mk(0, 1, 4'h7, 0, 4'h0,  1, 0, 0, 0, 4'h7, 1);
    vecs[34] = mk(0, 1, 4'h7, 0, 4'h0,  1, 0, 0, 0, 4'h7, 1);
    vecs[35] = mk(1, 1, 4'h7, 0, 4'h0,  0, 0, 0, 1, 4'h0, 0);
    vecs[36] = mk(0, 1, 4'h7, 1, 4'h2,  1, 0, 0, 0, 4'h0, 0); // LAST=B again -> A
    vecs[37] = mk(0, 1, 4'h7, 1, 4'h2,  1, 0, 0, 0, 4'h7, 1);

    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = 4'h0; b = 4'h0;
    rst1 = 1'b1; req_a1 = 1'b0; req_b1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
    #1;

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; req_a = vecs[i].req_a; a = vecs[i].a;
      req_b = vecs[i].req_b; b = vecs[i].b;
      tick();
      check($sformatf("v%0d gnt_a", i),   {3'b0, gnt_a},   {3'b0, vecs[i].gnt_a});
      check($sformatf("v%0d gnt_b", i),   {3'b0, gnt_b},   {3'b0, vecs[i].gnt_b});
      check($sformatf("v%0d s", i),       {3'b0, s},       {3'b0, vecs[i].s});
      check($sformatf("v%0d e", i),       {3'b0, e},       {3'b0, vecs[i].e});
      check($sformatf("v%0d y", i),       y,               vecs[i].y);
      check($sformatf("v%0d y_valid", i), {3'b0, y_valid}, {3'b0, vecs[i].y_valid});
    end

    // MAX_HOLD=1: alternate every beat while both request
    req_a1 = 1'b1; req_b1 = 1'b1; a1 = 4'h3; b1 = 4'hC;
    tick();
    rst1 = 1'b0;
    exp_q.push_back(4'h3); exp_q.push_back(4'hC);
    exp_q.push_back(4'h3); exp_q.push_back(4'hC);
    exp_q.push_back(4'h3);
    tick();
    check("mh1 first gnt_a", {3'b0, gnt_a1}, 4'h1);
    check("mh1 first y_valid", {3'b0, y_valid1}, 4'h0);
    for (int k = 2; k <= 6; k++) begin
      logic [3:0] ey;
      tick();
      ey = exp_q.pop_front();
      check($sformatf("mh1 c%0d gnt_a", k), {3'b0, gnt_a1}, {3'b0, logic'(k % 2 == 1)});
      check($sformatf("mh1 c%0d gnt_b", k), {3'b0, gnt_b1}, {3'b0, logic'(k % 2 == 0)});
      check($sformatf("mh1 c%0d s", k),     {3'b0, s1},     {3'b0, logic'(k % 2 == 0)});
      check($sformatf("mh1 c%0d y", k),     y1,             ey);
      check($sformatf("mh1 c%0d y_valid", k), {3'b0, y_valid1}, 4'h1);
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
